// File: rtl/ace_rd_responder.sv
// ace_rd_responder
//   ACE read-channel subordinate used as the memory model behind the fetch/load
//   path. It accepts one AR at a time and streams FIXED/INCR/WRAP bursts out of
//   an internal word array. Barriers get a single OKAY beat. Every burst ends
//   in WAIT_ACK until RACK arrives. The array is loaded through a byte-strobed
//   backdoor port that is independent of the state machine and of reset.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   arvalid/arready/araddr/arid/arlen/arsize/arburst/arsnoop/ardomain/arbar
//                               AR channel (arsnoop, ardomain, arbar[1] ignored)
//   rvalid/rready/rdata/rresp/rid/rlast
//                               R channel; rresp[3:2] (IsShared/PassDirty) = 0
//   rack                        read acknowledge, honoured only in WAIT_ACK
//   bd_we/bd_addr/bd_wdata/bd_wstrb
//                               backdoor word write with byte strobes
module ace_rd_responder #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int          AXADDR_WIDTH = 32,
  parameter int          XDATA_WIDTH  = 32,
  parameter int          XID_WIDTH    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         arvalid,
  output logic                         arready,
  input  logic [AXADDR_WIDTH-1:0]      araddr,
  input  logic [XID_WIDTH-1:0]         arid,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic [3:0]                   arsnoop,
  input  logic [1:0]                   ardomain,
  input  logic [1:0]                   arbar,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [XDATA_WIDTH-1:0]       rdata,
  output logic [3:0]                   rresp,
  output logic [XID_WIDTH-1:0]         rid,
  output logic                         rlast,
  input  logic                         rack,
  input  logic                         bd_we,
  input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
  input  logic [31:0]                  bd_wdata,
  input  logic [3:0]                   bd_wstrb
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [AXADDR_WIDTH-1:0] BASE      = AXADDR_WIDTH'(BASE_ADDR);
  localparam logic [AXADDR_WIDTH-1:0] ONE       = AXADDR_WIDTH'(1);
  localparam logic [AXADDR_WIDTH:0]   MEM_BYTES = (AXADDR_WIDTH+1)'(4 * MEM_WORDS);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BURST    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t                   r_state, w_state_nx;

  logic [31:0]              r_mem [MEM_WORDS];

  logic [AXADDR_WIDTH-1:0]  r_addr;
  logic [7:0]               r_len;
  logic [7:0]               r_cnt;
  logic [2:0]               r_size;
  logic [1:0]               r_burst;
  logic                     r_slverr;
  logic                     r_bar;
  logic [XID_WIDTH-1:0]     r_rid;
  logic [XDATA_WIDTH-1:0]   r_rdata;
  logic [1:0]               r_rresp;
  logic                     r_rlast;

  logic                     w_ar_hs;
  logic                     w_adv;
  logic                     w_load;
  logic                     w_ar_slverr;
  logic                     w_ld_slverr;
  logic                     w_ld_bar;
  logic [AXADDR_WIDTH-1:0]  w_bytes;
  logic [AXADDR_WIDTH-1:0]  w_wrap_tot;
  logic [AXADDR_WIDTH-1:0]  w_wrap_lo;
  logic [AXADDR_WIDTH-1:0]  w_inc;
  logic [AXADDR_WIDTH-1:0]  w_next;
  logic [AXADDR_WIDTH-1:0]  w_beat_addr;
  logic [AXADDR_WIDTH-1:0]  w_off;
  logic                     w_in_range;
  logic [AW-1:0]            w_idx;
  logic [1:0]               w_ld_resp;
  logic                     w_ld_zero;

  logic                     w_unused;
  assign w_unused = ^{arsnoop, ardomain, arbar[1]};

  // ---------------------------------------------------------------------------
  // Backdoor write port: works regardless of reset or FSM state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (bd_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bd_wstrb[i]) r_mem[bd_addr][8*i +: 8] <= bd_wdata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    arready    = 1'b0;
    rvalid     = 1'b0;
    case (r_state)
      IDLE: begin
        arready = rst_n;
        if (arvalid && rst_n) w_state_nx = BURST;
      end
      BURST: begin
        rvalid = 1'b1;
        if (rready && r_rlast) w_state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (rack) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat address generation
  // ---------------------------------------------------------------------------
  always_comb begin
    w_bytes    = ONE << r_size;
    // T is a power of two whenever WRAP is legal, so the mask is exact.
    w_wrap_tot = AXADDR_WIDTH'({1'b0, r_len} + 9'd1) << r_size;
    w_wrap_lo  = r_addr & ~(w_wrap_tot - ONE);
    w_inc      = r_addr + w_bytes;
    case (r_burst)
      BURST_FIXED: w_next = r_addr;
      BURST_INCR:  w_next = (r_addr & ~(w_bytes - ONE)) + w_bytes;
      // Offset compare keeps the wrap test correct modulo 2^32.
      BURST_WRAP:  w_next = ((w_inc - w_wrap_lo) >= w_wrap_tot) ? w_wrap_lo : w_inc;
      default:     w_next = r_addr;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Beat load: the beat that becomes valid at the next edge is either beat 0
  // of a newly accepted AR or the successor of the beat just handed over.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ar_hs     = arvalid && arready;
    w_adv       = (r_state == BURST) && rready && !r_rlast;
    w_load      = w_ar_hs || w_adv;
    w_ar_slverr = (arsize > 3'd2) || (arburst == 2'b11) ||
                  ((arburst == BURST_WRAP) &&
                   !((arlen == 8'd1) || (arlen == 8'd3) || (arlen == 8'd7) || (arlen == 8'd15)));
    w_ld_slverr = w_ar_hs ? w_ar_slverr : r_slverr;
    w_ld_bar    = w_ar_hs ? arbar[0]    : r_bar;
    w_beat_addr = w_ar_hs ? araddr      : w_next;
    w_off       = w_beat_addr - BASE;
    w_in_range  = {1'b0, w_off} < MEM_BYTES;
    w_idx       = w_off[AW+1:2];
    if (w_ld_bar)         w_ld_resp = RESP_OKAY;
    else if (w_ld_slverr) w_ld_resp = RESP_SLVERR;
    else if (!w_in_range) w_ld_resp = RESP_DECERR;
    else                  w_ld_resp = RESP_OKAY;
    w_ld_zero   = w_ld_bar || w_ld_slverr || !w_in_range;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_slverr <= 1'b0;
      r_bar    <= 1'b0;
      r_rid    <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_rlast  <= 1'b0;
    end else if (w_load) begin
      if (w_ar_hs) begin
        r_addr   <= araddr;
        r_len    <= arlen;
        r_cnt    <= 8'd0;
        r_size   <= arsize;
        r_burst  <= arburst;
        r_slverr <= w_ar_slverr;
        r_bar    <= arbar[0];
        r_rid    <= arid;
        r_rlast  <= arbar[0] || (arlen == 8'd0);
      end else begin
        r_addr   <= w_next;
        r_cnt    <= r_cnt + 8'd1;
        r_rlast  <= (r_cnt + 8'd1) == r_len;
      end
      // Array read sees the pre-edge contents, so a same-cycle backdoor
      // write to this word is not visible in this beat.
      r_rdata <= w_ld_zero ? '0 : XDATA_WIDTH'(r_mem[w_idx]);
      r_rresp <= w_ld_resp;
    end
  end

  assign rdata = r_rdata;
  assign rresp = {2'b00, r_rresp};
  assign rid   = r_rid;
  assign rlast = r_rlast;

endmodule

// File: tb/tb_ace_rd_responder.sv
// Randomized bench for ace_rd_responder: a shadow memory and a beat-list
// model built from the burst address rules are compared against every R beat.
module tb_ace_rd_responder;

  localparam int          MW   = 4096;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [0:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arsnoop;
  logic [1:0]  ardomain;
  logic [1:0]  arbar;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rresp;
  logic [0:0]  rid;
  logic        rlast;
  logic        rack;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [31:0] bd_wdata;
  logic [3:0]  bd_wstrb;

  ace_rd_responder dut (
    .clk(clk), .rst_n(rst_n),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen(arlen), .arsize(arsize), .arburst(arburst), .arsnoop(arsnoop),
    .ardomain(ardomain), .arbar(arbar),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast), .rack(rack),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_wstrb(bd_wstrb)
  );

  always #5 clk = ~clk;

  int unsigned shmem [MW];
  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] e_data [$];
  logic [3:0]  e_resp [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the next negedge with the write done.
  task automatic bd_write(input int idx, input logic [31:0] d, input logic [3:0] strb);
    bd_we = 1'b1; bd_addr = 12'(idx); bd_wdata = d; bd_wstrb = strb;
    @(negedge clk);
    bd_we = 1'b0;
    for (int i = 0; i < 4; i++)
      if (strb[i]) shmem[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  // Expected beats from the burst rules, using wide arithmetic and % masks.
  task automatic build_exp(input logic [31:0] addr, input int len, input int size,
                           input int burst, input bit bar);
    longint unsigned a, b, t, lower, n, off;
    bit slv;
    int nb;
    e_data.delete(); e_resp.delete();
    slv = (size > 2) || (burst == 3) ||
          (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    nb  = bar ? 1 : len + 1;
    a   = addr;
    b   = 64'd1 << size;
    for (int k = 0; k < nb; k++) begin
      off = (a - BASE) % (64'd1 << 32);
      if (bar)               begin e_data.push_back(0); e_resp.push_back(4'd0); end
      else if (slv)          begin e_data.push_back(0); e_resp.push_back(4'd2); end
      else if (off >= 4*MW)  begin e_data.push_back(0); e_resp.push_back(4'd3); end
      else                   begin e_data.push_back(shmem[off/4]); e_resp.push_back(4'd0); end
      case (burst)
        0: n = a;
        1: n = (a - (a % b)) + b;
        2: begin
          t = (len + 1) * b;
          lower = a - (a % t);
          n = a + b;
          if (n >= lower + t) n = lower;
        end
        default: n = a;
      endcase
      a = n % (64'd1 << 32);
    end
  endtask

  // ackd < 0 picks a random RACK delay; early asserts RACK with the last beat.
  task automatic run_txn(input logic [31:0] addr, input int len, input int size,
                         input int burst, input bit bar, input bit id,
                         input bit rnd_ready, input bit clash, input int ackd,
                         input bit early);
    int n, k, cyc, nb, w;
    bit stalled;
    logic [37:0] held;
    logic [31:0] cd;
    build_exp(addr, len, size, burst, bar);
    nb = e_data.size();
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; arlen = 8'(len); arsize = 3'(size);
    arburst = 2'(burst); arbar = {1'b0, bar}; arid = id;
    arsnoop = 4'($urandom); ardomain = 2'($urandom); rack = 1'b0; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin chk("ar_timeout", 0, 1); arvalid = 1'b0; return; end
    cd = $urandom;
    if (clash) begin
      bd_we = 1'b1; bd_addr = 12'((addr - BASE) >> 2); bd_wdata = cd; bd_wstrb = 4'hF;
    end
    @(negedge clk);
    arvalid = 1'b0;
    if (clash) begin bd_we = 1'b0; shmem[(addr - BASE) >> 2] = cd; end
    chk("r_latency", rvalid, 1);
    k = 0; cyc = 0; stalled = 0; held = '0;
    while (k < nb && cyc < 3000) begin
      rready = rnd_ready ? 1'($urandom) : 1'b1;
      rack   = early && rready && (k == nb - 1);
      if (stalled) chk("hold", {rdata, rresp, rlast, rid}, held);
      if (rvalid && rready) begin
        chk("rdata", rdata, e_data[k]);
        chk("rresp", rresp, e_resp[k]);
        chk("rlast", rlast, (k == nb - 1));
        chk("rid",   rid,   id);
        k++; stalled = 0;
      end else if (rvalid) begin
        stalled = 1; held = {rdata, rresp, rlast, rid};
      end else begin
        chk("rvalid_drop", rvalid, 1);
      end
      @(negedge clk); cyc++;
    end
    if (k < nb) chk("r_timeout", k, nb);
    rready = 1'b0; rack = 1'b0;
    chk("rvalid_after_last", rvalid, 0);
    chk("arready_wait_ack", arready, 0);
    w = (ackd < 0) ? $urandom_range(0, 3) : ackd;
    if (w > 0) begin
      repeat (w) @(negedge clk);
      chk("arready_no_rack", arready, 0);
    end
    rack = 1'b1;
    @(negedge clk);
    rack = 1'b0;
    chk("arready_after_rack", arready, 1);
  endtask

  initial begin
    logic [31:0] a;
    int len, size, burst;
    rst_n = 1'b0; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0;
    arburst = '0; arsnoop = '0; ardomain = '0; arbar = '0; rready = 1'b0; rack = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0; bd_wstrb = '0;

    // Preload during reset (backdoor is independent of reset).
    @(negedge clk);
    for (int i = 0; i < MW; i++) bd_write(i, $urandom, 4'hF);
    chk("arready_in_reset", arready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_rvalid",  rvalid, 0);
    chk("rst_rlast",   rlast, 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_rresp",   rresp, 0);
    chk("rst_rid",     rid, 0);

    bd_write(0, 32'h1111_1111, 4'hF);
    bd_write(1, 32'h2222_2222, 4'hF);
    bd_write(2, 32'h3333_3333, 4'hF);
    bd_write(3, 32'h4444_4444, 4'hF);
    bd_write(10, 32'hAABB_CCDD, 4'b0101);

    // Directed cases.
    run_txn(BASE,                  3, 2, 1, 0, 1, 0, 0, 0, 0);   // INCR words 0..3
    run_txn(BASE + 8,              3, 2, 2, 0, 0, 0, 0, 1, 0);   // WRAP 2,3,0,1
    run_txn(32'h0,                 1, 2, 1, 0, 1, 0, 0, 0, 1);   // DECERR both
    run_txn(BASE + 4*MW - 4,       1, 2, 1, 0, 0, 0, 0, 0, 0);   // OKAY then DECERR
    run_txn(BASE,                  2, 3, 1, 0, 1, 0, 0, 0, 0);   // size 3 SLVERR
    run_txn(BASE,                  2, 2, 2, 0, 0, 0, 0, 0, 0);   // WRAP len 2 SLVERR
    run_txn(BASE + 40,             1, 2, 3, 0, 0, 0, 0, 0, 0);   // reserved burst
    run_txn(BASE + 64,            15, 2, 1, 0, 1, 1, 0, 2, 0);   // stalled 16-beat
    run_txn(BASE + 12,             7, 2, 1, 1, 1, 0, 0, 5, 0);   // barrier, rack late
    run_txn(BASE + 40,             0, 2, 1, 0, 0, 0, 1, 0, 0);   // same-cycle backdoor
    run_txn(BASE + 40,             0, 2, 1, 0, 0, 0, 0, 0, 0);   // new data visible
    run_txn(BASE + 1,              3, 0, 1, 0, 0, 1, 0, 0, 0);   // byte INCR unaligned
    run_txn(BASE + 6,              3, 1, 0, 0, 1, 0, 0, 0, 0);   // FIXED halfword
    run_txn(BASE + 256,          255, 2, 1, 0, 0, 1, 0, -1, 1);  // 256 beats

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      burst = $urandom_range(0, 3);
      size  = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2) begin
        case ($urandom_range(0, 4))
          0: len = 1; 1: len = 3; 2: len = 7; 3: len = 15; default: len = 2;
        endcase
      end else len = $urandom_range(0, 16);
      case ($urandom_range(0, 5))
        0:       a = BASE + 4*MW - 32'($urandom_range(0, 24));
        1:       a = BASE - 32'($urandom_range(1, 16));
        default: a = BASE + 32'($urandom_range(0, 4*MW - 1));
      endcase
      run_txn(a, len, size, burst, ($urandom_range(0, 9) == 0), 1'($urandom),
              1'($urandom), 0, -1, 1'($urandom));
    end

    // Reset in the middle of a stalled burst.
    @(negedge clk);
    arvalid = 1'b1; araddr = BASE; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    arbar = 2'b00; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    chk("mid_rvalid", rvalid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    bd_write(100, 32'h5A5A_1234, 4'hF);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_arready", arready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_arready", arready, 1);
    chk("post_reset_rvalid", rvalid, 0);
    run_txn(BASE,       3, 2, 1, 0, 1, 0, 0, 0, 0);
    run_txn(BASE + 400, 0, 2, 1, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
